// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared register-file constants and address helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int c_XLEN = 32;
  localparam int c_NREG = 32;

  function automatic int addr_width(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  // An address names real, writable storage: inside the array and not a hardwired x0.
  function automatic logic addr_live(input int addr, input int nreg, input bit zero_x0);
    return (addr < nreg) && !(zero_x0 && (addr == 0));
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register pending-write bits with issue/write update and
//               three combinational busy lookups.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG    = c_NREG,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_X0 = 1'b1,
  localparam int AW     = addr_width(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr_rd,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  input  logic [AW-1:0] raddr_rs1,
  input  logic [AW-1:0] raddr_rs2,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          issue_busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;
  logic            w_wr_live;
  logic            w_iss_live;

  assign w_wr_live  = we && addr_live(int'(waddr_rd), NREG, ZERO_X0);
  assign w_iss_live = issue_valid && addr_live(int'(issue_rd), NREG, ZERO_X0);

  for (genvar i = 0; i < NREG; i++) begin : g_bit
    assign w_set[i] = w_iss_live && (issue_rd == AW'(i));
    assign w_clr[i] = w_wr_live && (waddr_rd == AW'(i));
  end

  // Set is applied after clear so a same-cycle issue keeps the register pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= (r_busy & ~w_clr) | w_set;
  end

  function automatic logic lookup(input logic [NREG-1:0] busy,
                                  input logic [AW-1:0]   addr,
                                  input logic            wr_live,
                                  input logic [AW-1:0]   waddr);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NREG; i++)
      if (addr == AW'(i)) hit = busy[i];
    if (!addr_live(int'(addr), NREG, ZERO_X0)) hit = 1'b0;
    if (BYPASS && wr_live && (waddr == addr))  hit = 1'b0;
    return hit;
  endfunction

  assign rs1_busy   = lookup(r_busy, raddr_rs1, w_wr_live, waddr_rd);
  assign rs2_busy   = lookup(r_busy, raddr_rs2, w_wr_live, waddr_rd);
  assign issue_busy = lookup(r_busy, issue_rd,  w_wr_live, waddr_rd);

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb
// Description : 2R/1W integer register file with optional write bypass,
//               hardwired x0 and a pending-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int XLEN    = c_XLEN,
  parameter int NREG    = c_NREG,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_X0 = 1'b1,
  localparam int AW     = addr_width(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   raddr_rs1,
  input  logic [AW-1:0]   raddr_rs2,
  output logic [XLEN-1:0] rdata_rs1,
  output logic [XLEN-1:0] rdata_rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            we,
  input  logic [AW-1:0]   waddr_rd,
  input  logic [XLEN-1:0] wdata_rd,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_busy
);

  logic [XLEN-1:0] r_mem [NREG];
  logic            w_wr_live;
  logic            w_byp1;
  logic            w_byp2;

  assign w_wr_live = we && addr_live(int'(waddr_rd), NREG, ZERO_X0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++)
        if (w_wr_live && (waddr_rd == AW'(i))) r_mem[i] <= wdata_rd;
    end
  end

  // Forwarding is held off during reset so every output reads zero there.
  assign w_byp1 = BYPASS && rst_n && w_wr_live && (waddr_rd == raddr_rs1);
  assign w_byp2 = BYPASS && rst_n && w_wr_live && (waddr_rd == raddr_rs2);

  always_comb begin
    rdata_rs1 = '0;
    for (int i = 0; i < NREG; i++)
      if (raddr_rs1 == AW'(i)) rdata_rs1 = r_mem[i];
    if (!addr_live(int'(raddr_rs1), NREG, ZERO_X0)) rdata_rs1 = '0;
    if (w_byp1) rdata_rs1 = wdata_rd;
  end

  always_comb begin
    rdata_rs2 = '0;
    for (int i = 0; i < NREG; i++)
      if (raddr_rs2 == AW'(i)) rdata_rs2 = r_mem[i];
    if (!addr_live(int'(raddr_rs2), NREG, ZERO_X0)) rdata_rs2 = '0;
    if (w_byp2) rdata_rs2 = wdata_rd;
  end

  reg_scoreboard #(
    .NREG    (NREG),
    .BYPASS  (BYPASS),
    .ZERO_X0 (ZERO_X0)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .we          (we),
    .waddr_rd    (waddr_rd),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .raddr_rs1   (raddr_rs1),
    .raddr_rs2   (raddr_rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .issue_busy  (issue_busy)
  );

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_sb
// Description : Directed bench for reg_file_sb: default, no-bypass and
//               24-register instances share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  raddr_rs1, raddr_rs2, waddr_rd, issue_rd;
  logic        we, issue_valid;
  logic [31:0] wdata_rd;

  logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2, c_rd1, c_rd2;
  logic        a_b1, a_b2, a_ib, b_b1, b_b2, b_ib, c_b1, c_b2, c_ib;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_file_sb u_a (
    .clk(clk), .rst_n(rst_n), .raddr_rs1(raddr_rs1), .raddr_rs2(raddr_rs2),
    .rdata_rs1(a_rd1), .rdata_rs2(a_rd2), .rs1_busy(a_b1), .rs2_busy(a_b2),
    .we(we), .waddr_rd(waddr_rd), .wdata_rd(wdata_rd),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_busy(a_ib)
  );

  reg_file_sb #(.BYPASS(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .raddr_rs1(raddr_rs1), .raddr_rs2(raddr_rs2),
    .rdata_rs1(b_rd1), .rdata_rs2(b_rd2), .rs1_busy(b_b1), .rs2_busy(b_b2),
    .we(we), .waddr_rd(waddr_rd), .wdata_rd(wdata_rd),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_busy(b_ib)
  );

  reg_file_sb #(.NREG(24)) u_c (
    .clk(clk), .rst_n(rst_n), .raddr_rs1(raddr_rs1), .raddr_rs2(raddr_rs2),
    .rdata_rs1(c_rd1), .rdata_rs2(c_rd2), .rs1_busy(c_b1), .rs2_busy(c_b2),
    .we(we), .waddr_rd(waddr_rd), .wdata_rd(wdata_rd),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_busy(c_ib)
  );

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [66:0] obs;
    for (int a = 0; a < 32; a++) begin
      raddr_rs1 = 5'(a); raddr_rs2 = 5'(a); issue_rd = 5'(a);
      #1;
      obs = {a_rd1, a_rd2, a_b1, a_b2, a_ib};
      total++;
      if (obs !== 67'd0) begin
        bad++; $display("FAIL reset_read addr=%0d: got %h want 0", a, obs);
      end
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_reset_midwrite();
    go();
    we = 1'b1; waddr_rd = 5'd5; wdata_rd = 32'hDEADBEEF;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 we = 1'b0;
    #2 rst_n = 1'b1;
    raddr_rs1 = 5'd5;
    #1;
    total++;
    if (a_rd1 !== 32'h0) begin bad++; $display("FAIL midwrite_reset_a: got %h want 0", a_rd1); end
    total++;
    if (b_rd1 !== 32'h0) begin bad++; $display("FAIL midwrite_reset_b: got %h want 0", b_rd1); end
  endtask

  task automatic test_write_read();
    go();
    we = 1'b1; waddr_rd = 5'd7; wdata_rd = 32'hA5A5A5A5;
    go();
    we = 1'b0; raddr_rs1 = 5'd7; raddr_rs2 = 5'd7;
    #1;
    total++;
    if (a_rd1 !== 32'hA5A5A5A5) begin bad++; $display("FAIL wr_r7_rs1: got %h want a5a5a5a5", a_rd1); end
    total++;
    if (a_rd2 !== 32'hA5A5A5A5) begin bad++; $display("FAIL wr_r7_rs2: got %h want a5a5a5a5", a_rd2); end
    total++;
    if (b_rd2 !== 32'hA5A5A5A5) begin bad++; $display("FAIL wr_r7_nobyp: got %h want a5a5a5a5", b_rd2); end
    we = 1'b1; waddr_rd = 5'd0; wdata_rd = 32'h1234; raddr_rs1 = 5'd0;
    #1;
    total++;
    if (a_rd1 !== 32'h0) begin bad++; $display("FAIL x0_bypass: got %h want 0", a_rd1); end
    go();
    we = 1'b0;
    #1;
    total++;
    if (a_rd1 !== 32'h0) begin bad++; $display("FAIL x0_write: got %h want 0", a_rd1); end
  endtask

  task automatic test_bypass();
    go();
    we = 1'b1; waddr_rd = 5'd3; wdata_rd = 32'h55; raddr_rs1 = 5'd3;
    #1;
    total++;
    if (a_rd1 !== 32'h55) begin bad++; $display("FAIL bypass_same_cycle: got %h want 55", a_rd1); end
    total++;
    if (b_rd1 !== 32'h0) begin bad++; $display("FAIL nobypass_old: got %h want 0", b_rd1); end
    go();
    we = 1'b0;
    #1;
    total++;
    if (b_rd1 !== 32'h55) begin bad++; $display("FAIL nobypass_next: got %h want 55", b_rd1); end
  endtask

  task automatic test_busy();
    go();
    issue_valid = 1'b1; issue_rd = 5'd9; raddr_rs2 = 5'd9;
    #1;
    total++;
    if ({a_b2, a_ib} !== 2'b00) begin bad++; $display("FAIL busy_before_edge: got %b want 00", {a_b2, a_ib}); end
    go();
    issue_valid = 1'b0;
    #1;
    total++;
    if ({a_b2, b_b2} !== 2'b11) begin bad++; $display("FAIL busy_set: got %b want 11", {a_b2, b_b2}); end
    we = 1'b1; waddr_rd = 5'd9; wdata_rd = 32'h99;
    #1;
    total++;
    if ({a_b2, b_b2} !== 2'b01) begin bad++; $display("FAIL busy_clear_bypass: got %b want 01", {a_b2, b_b2}); end
    total++;
    if (a_rd2 !== 32'h99) begin bad++; $display("FAIL busy_write_data: got %h want 99", a_rd2); end
    go();
    we = 1'b0;
    #1;
    total++;
    if ({a_b2, b_b2} !== 2'b00) begin bad++; $display("FAIL busy_clear_edge: got %b want 00", {a_b2, b_b2}); end
    total++;
    if (b_rd2 !== 32'h99) begin bad++; $display("FAIL busy_data_nobyp: got %h want 99", b_rd2); end
  endtask

  task automatic test_set_wins();
    go();
    issue_valid = 1'b1; issue_rd = 5'd4; we = 1'b1; waddr_rd = 5'd4;
    wdata_rd = 32'h77; raddr_rs1 = 5'd4;
    go();
    issue_valid = 1'b0; we = 1'b0;
    #1;
    total++;
    if (a_rd1 !== 32'h77) begin bad++; $display("FAIL setwins_data: got %h want 77", a_rd1); end
    total++;
    if ({a_b1, b_b1} !== 2'b11) begin bad++; $display("FAIL setwins_busy: got %b want 11", {a_b1, b_b1}); end
    issue_valid = 1'b1;
    #1;
    total++;
    if (a_ib !== 1'b1) begin bad++; $display("FAIL reissue_waw: got %b want 1", a_ib); end
    we = 1'b1; wdata_rd = 32'h78;
    #1;
    total++;
    if ({a_ib, b_ib} !== 2'b01) begin bad++; $display("FAIL issue_busy_bypass: got %b want 01", {a_ib, b_ib}); end
    go();
    issue_valid = 1'b0; we = 1'b0;
    #1;
    total++;
    if ({a_b1, a_rd1} !== {1'b1, 32'h78}) begin bad++; $display("FAIL reissue_write: got %b/%h want 1/78", a_b1, a_rd1); end
  endtask

  task automatic test_x0_issue();
    go();
    issue_valid = 1'b1; issue_rd = 5'd0;
    go();
    issue_valid = 1'b0; raddr_rs1 = 5'd0;
    #1;
    total++;
    if ({a_b1, a_ib, b_b1} !== 3'b000) begin bad++; $display("FAIL x0_busy: got %b want 000", {a_b1, a_ib, b_b1}); end
  endtask

  task automatic test_out_of_range();
    go();
    we = 1'b1; waddr_rd = 5'd30; wdata_rd = 32'hFF;
    issue_valid = 1'b1; issue_rd = 5'd30; raddr_rs1 = 5'd30;
    #1;
    total++;
    if ({c_rd1, c_b1} !== 33'd0) begin bad++; $display("FAIL oor_bypass: got %h want 0", {c_rd1, c_b1}); end
    total++;
    if (a_rd1 !== 32'hFF) begin bad++; $display("FAIL r30_bypass_n32: got %h want ff", a_rd1); end
    go();
    we = 1'b0; issue_valid = 1'b0;
    #1;
    total++;
    if ({c_rd1, c_b1, c_ib} !== 34'd0) begin bad++; $display("FAIL oor_read: got %h want 0", {c_rd1, c_b1, c_ib}); end
    total++;
    if ({a_rd1, a_b1} !== {32'hFF, 1'b1}) begin bad++; $display("FAIL r30_n32: got %h want 1ff", {a_rd1, a_b1}); end
    we = 1'b1; waddr_rd = 5'd23; wdata_rd = 32'h23;
    go();
    we = 1'b0; raddr_rs1 = 5'd23;
    #1;
    total++;
    if (c_rd1 !== 32'h23) begin bad++; $display("FAIL n24_top_reg: got %h want 23", c_rd1); end
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; issue_valid = 1'b0;
    raddr_rs1 = '0; raddr_rs2 = '0; waddr_rd = '0; issue_rd = '0; wdata_rd = '0;
    #12;
    test_reset();
    test_reset_midwrite();
    test_write_read();
    test_bypass();
    test_busy();
    test_set_wins();
    test_x0_issue();
    test_out_of_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
